// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared definitions for the traffic-light controller and its input-side
// companions: the 2-bit controller/request state encoding and the default
// board timing constants used to size debounce and stuck-sensor windows.
package traffic_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAITING = 2'd1;
  localparam logic [1:0] ST_SERVING = 2'd2;
  localparam logic [1:0] ST_FAULT   = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    WAITING = ST_WAITING,
    SERVING = ST_SERVING,
    FAULT   = ST_FAULT
  } req_state_t;

  localparam int CLK_HZ      = 10_000_000;
  localparam int DEBOUNCE_MS = 10;

  // Cycles in one debounce window at the board clock (100000 at 10 MHz).
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

  // One minute of continuous vehicle presence at the board clock.
  localparam int STUCK_CYCLES_DEFAULT = 600_000_000;

endpackage

// File: rtl/vehicle_sensor_conditioner_if.sv
// vehicle_sensor_conditioner_if
// Bundles the sensor-side and controller-side signals of the vehicle sensor
// conditioner.
//   master : drives sensorRaw, secondaryGreen, fault; observes the outputs
//   slave  : the conditioner; consumes the inputs, drives vehicleWaiting,
//            sensorFault, requestCount and sensorStable
interface vehicle_sensor_conditioner_if;
  logic       sensorRaw;
  logic       secondaryGreen;
  logic       fault;
  logic       vehicleWaiting;
  logic       sensorFault;
  logic [7:0] requestCount;
  logic       sensorStable;

  modport master (
    output sensorRaw,
    output secondaryGreen,
    output fault,
    input  vehicleWaiting,
    input  sensorFault,
    input  requestCount,
    input  sensorStable
  );

  modport slave (
    input  sensorRaw,
    input  secondaryGreen,
    input  fault,
    output vehicleWaiting,
    output sensorFault,
    output requestCount,
    output sensorStable
  );
endinterface

// File: rtl/sensor_debounce.sv
// sensor_debounce
// Two-flop synchronizer followed by a disagreement-run debouncer. The stable
// level only changes after DEBOUNCE_CYCLES consecutive cycles in which the
// synchronized input differs from it; any agreeing cycle restarts the run.
// Reused for the board push-buttons.
//   clk          : system clock
//   reset        : synchronous, active-high
//   sensorRaw    : asynchronous raw level
//   sensorStable : registered debounced level
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic sensorRaw,
  output logic sensorStable
);

  // A single-cycle window still needs a 1-bit counter to stay legal.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync_p0;
  logic            sync_p1;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0      <= 1'b0;
      sync_p1      <= 1'b0;
      db_cnt       <= '0;
      sensorStable <= 1'b0;
    end else begin
      // p0 -> p1: metastability settling; p1 is the synchronized level
      sync_p0 <= sensorRaw;
      sync_p1 <= sync_p0;
      // p1 -> stable: debounce
      if (sync_p1 == sensorStable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        sensorStable <= sync_p1;
        db_cnt       <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// vehicle_sensor_conditioner
// Turns the raw secondary-road vehicle sensor into a latched vehicle-waiting
// request for the traffic-light controller. The request is held until the
// controller shows secondary green. A sensor that stays high for
// STUCK_CYCLES is flagged as stuck; while any fault is present the request
// is forced high so the secondary road is never starved.
//   clk    : 10 MHz system clock
//   reset  : synchronous, active-high
//   bus    : slave modport carrying sensorRaw, secondaryGreen, fault in and
//            vehicleWaiting, sensorFault, requestCount[7:0], sensorStable out
module vehicle_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int STUCK_CYCLES    = STUCK_CYCLES_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  vehicle_sensor_conditioner_if.slave  bus
);

  localparam int STUCK_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

  logic               sensor_stable;
  logic               stable_q;
  logic               rise;
  logic [STUCK_W-1:0] stuck_cnt;
  logic               sensor_fault;
  req_state_t         state;
  logic               vehicle_waiting;
  logic [7:0]         request_count;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .sensorRaw   (bus.sensorRaw),
    .sensorStable(sensor_stable)
  );

  assign rise = sensor_stable & ~stable_q;

  // Stuck detector. The flag is qualified with the current stable level so
  // it drops on the edge right after the sensor releases, not one later.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q     <= 1'b0;
      stuck_cnt    <= '0;
      sensor_fault <= 1'b0;
    end else begin
      stable_q     <= sensor_stable;
      sensor_fault <= sensor_stable && (stuck_cnt == STUCK_MAX);
      if (!sensor_stable) begin
        stuck_cnt <= '0;
      end else if (stuck_cnt != STUCK_MAX) begin
        stuck_cnt <= stuck_cnt + STUCK_W'(1);
      end
    end
  end

  // Request FSM. vehicle_waiting is decoded from the state being entered so
  // it changes on the same edge as the transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      vehicle_waiting <= 1'b0;
      request_count   <= 8'd0;
    end else if (bus.fault || sensor_fault) begin
      state           <= FAULT;
      vehicle_waiting <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state           <= WAITING;
            vehicle_waiting <= 1'b1;
            request_count   <= request_count + 8'd1;
          end else begin
            vehicle_waiting <= 1'b0;
          end
        end
        WAITING: begin
          if (bus.secondaryGreen) begin
            state           <= SERVING;
            vehicle_waiting <= 1'b0;
          end else begin
            vehicle_waiting <= 1'b1;
          end
        end
        SERVING: begin
          // A vehicle still present when green ends re-requests without
          // being counted as a new arrival.
          if (!bus.secondaryGreen && sensor_stable) begin
            state           <= WAITING;
            vehicle_waiting <= 1'b1;
          end else if (!bus.secondaryGreen) begin
            state           <= IDLE;
            vehicle_waiting <= 1'b0;
          end else begin
            vehicle_waiting <= 1'b0;
          end
        end
        FAULT: begin
          // Reaching here means both fault sources are already clear.
          state           <= IDLE;
          vehicle_waiting <= 1'b0;
        end
        default: begin
          state           <= IDLE;
          vehicle_waiting <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vehicleWaiting = vehicle_waiting;
  assign bus.sensorFault    = sensor_fault;
  assign bus.requestCount   = request_count;
  assign bus.sensorStable   = sensor_stable;

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
module tb_vehicle_sensor_conditioner;

  localparam int DEB = 4;
  localparam int STK = 20;

  localparam int M_IDLE    = 0;
  localparam int M_WAITING = 1;
  localparam int M_SERVING = 2;
  localparam int M_FAULT   = 3;

  logic clk;
  logic rst;

  vehicle_sensor_conditioner_if bus ();

  vehicle_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .STUCK_CYCLES   (STK)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       vw;
    logic       sf;
    logic [7:0] cnt;
    logic       st;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   n_cycle  = 0;

  // Reference model state: values visible before the next edge.
  bit raw_d1, raw_d2;   // raw level one and two edges ago
  int run_len;          // consecutive edges the synced level has disagreed
  bit m_st, m_st_prev, m_sf;
  int m_mode, m_cnt, m_edge, m_rise_at;

  // Apply one cycle of inputs and predict the outputs after the next edge.
  task automatic cyc(input bit raw, input bit green, input bit flt, input bit r);
    bit sync_lvl, rise, n_st, n_sf;
    int n_mode, n_cnt;
    obs_t e;
    @(negedge clk);
    bus.sensorRaw      = raw;
    bus.secondaryGreen = green;
    bus.fault          = flt;
    rst                = r;
    m_edge++;
    if (r) begin
      raw_d1 = 0; raw_d2 = 0; run_len = 0;
      m_st = 0; m_st_prev = 0; m_sf = 0; m_mode = M_IDLE; m_cnt = 0;
    end else begin
      rise   = m_st && !m_st_prev;
      n_cnt  = m_cnt;
      n_mode = m_mode;
      if (flt || m_sf) n_mode = M_FAULT;
      else if (m_mode == M_IDLE && rise) begin
        n_mode = M_WAITING;
        n_cnt  = (m_cnt + 1) % 256;
      end else if (m_mode == M_WAITING && green) n_mode = M_SERVING;
      else if (m_mode == M_SERVING && !green) n_mode = m_st ? M_WAITING : M_IDLE;
      else if (m_mode == M_FAULT) n_mode = M_IDLE;
      // stuck: high for more than STK edges since the stable level rose
      n_sf = m_st && (m_edge - m_rise_at >= STK + 1);
      sync_lvl = raw_d2;
      n_st = m_st;
      if (sync_lvl != m_st) begin
        run_len++;
        if (run_len == DEB) begin
          n_st = sync_lvl;
          run_len = 0;
          if (n_st) m_rise_at = m_edge;
        end
      end else run_len = 0;
      raw_d2 = raw_d1; raw_d1 = raw;
      m_st_prev = m_st; m_st = n_st; m_sf = n_sf;
      m_mode = n_mode; m_cnt = n_cnt;
    end
    e.vw  = (m_mode == M_WAITING) || (m_mode == M_FAULT);
    e.sf  = m_sf;
    e.cnt = 8'(m_cnt);
    e.st  = m_st;
    exp_q.push_back(e);
  endtask

  task automatic hold(input int n, input bit raw, input bit green, input bit flt);
    for (int i = 0; i < n; i++) cyc(raw, green, flt, 1'b0);
  endtask

  // Monitor: one comparison per edge for which an expectation was queued.
  always @(posedge clk) begin
    obs_t a, e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.vw  = bus.vehicleWaiting;
      a.sf  = bus.sensorFault;
      a.cnt = bus.requestCount;
      a.st  = bus.sensorStable;
      n_cycle++;
      n_checks++;
      if (a !== e) begin
        n_fails++;
        $display("FAIL outputs edge %0d: got vw=%0b sf=%0b cnt=%0d st=%0b, required vw=%0b sf=%0b cnt=%0d st=%0b",
                 n_cycle, a.vw, a.sf, a.cnt, a.st, e.vw, e.sf, e.cnt, e.st);
      end
    end
  end

  initial begin
    bit r_raw, r_green, r_flt, r_rst;
    raw_d1 = 0; raw_d2 = 0; run_len = 0;
    m_st = 0; m_st_prev = 0; m_sf = 0; m_mode = M_IDLE; m_cnt = 0;
    m_edge = 0; m_rise_at = 0;
    bus.sensorRaw = 0; bus.secondaryGreen = 0; bus.fault = 0; rst = 1;

    // reset, then sensor held high: stable at edge 6, request at edge 7
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    hold(10, 1, 0, 0);
    // acknowledge; drop sensor while green, then green off -> idle
    hold(10, 0, 1, 0);
    hold(4, 0, 0, 0);
    // new request; green ends with vehicle still present -> waiting again
    hold(10, 1, 0, 0);
    hold(3, 1, 1, 0);
    hold(3, 1, 0, 0);
    hold(3, 1, 1, 0);
    hold(10, 0, 1, 0);
    hold(4, 0, 0, 0);
    // glitches of 1, 2, 3 cycles with 5-cycle gaps never get through
    for (int w = 1; w <= 3; w++) begin
      hold(w, 1, 0, 0);
      hold(5, 0, 0, 0);
    end
    // rise coincident with green: one-cycle request pulse, then serving
    hold(6, 1, 0, 0);
    hold(4, 1, 1, 0);
    hold(10, 0, 1, 0);
    hold(3, 0, 0, 0);
    // system fault in idle
    hold(3, 0, 0, 1);
    hold(3, 0, 0, 0);
    // stuck sensor, then release
    hold(40, 1, 0, 0);
    hold(15, 0, 0, 0);
    // 256 served requests wrap the counter
    for (int k = 0; k < 256; k++) begin
      hold(8, 1, 0, 0);
      hold(8, 0, 1, 0);
      hold(1, 0, 0, 0);
    end
    // randomized traffic
    r_raw = 0; r_green = 0; r_flt = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) r_raw = ~r_raw;
      if ($urandom_range(0, 7) == 0) r_green = ~r_green;
      r_flt = ($urandom_range(0, 99) < 3);
      r_rst = ($urandom_range(0, 499) == 0);
      cyc(r_raw, r_green, r_flt, r_rst);
    end
    // reset in the middle of WAITING
    hold(6, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    hold(9, 1, 0, 0);
    cyc(1, 0, 1, 1);
    hold(3, 0, 0, 0);

    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
